// File: rtl/store_drain_unit.sv
// Purpose : drains retired stores from the store_buffer head to the dcache write port, in order, one at a time.
// Latency : a store retired in cycle N is popped in N+1 and requested in N+2; at most one store per 2 cycles.
// Backpressure: data_req and data_* are held while data_addr_ok=0; no further pop until data_data_ok retires the write.
//
// Ports:
//   clk, resetn            clock and asynchronous active-low reset
//   rob_commit_store       per retire slot: a store retires this cycle
//   commit_store_valid     pop strobe to the store_buffer head (combinational from registers)
//   commit_store_*         head entry fields, sampled on the pop
//   data_req/data_wr       dcache write request (data_wr mirrors data_req)
//   data_size/addr/wstrb/wdata  registered request fields
//   data_addr_ok           dcache accepted the request
//   data_data_ok           dcache completed the write
//   pending_cnt            retired stores still sitting in the store_buffer
//   store_drained          nothing pending and no write in flight
module store_drain_unit #(
  parameter int STORE_GROUP  = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int CNT_W        = $clog2(STORE_GROUP + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [COMMIT_WIDTH-1:0] rob_commit_store,
  output logic                    commit_store_valid,
  input  logic [3:0]              commit_store_wstrb,
  input  logic [2:0]              commit_store_size,
  input  logic [31:0]             commit_store_addr,
  input  logic [31:0]             commit_store_data,
  output logic                    data_req,
  output logic                    data_wr,
  output logic [2:0]              data_size,
  output logic [31:0]             data_addr,
  output logic [3:0]              data_wstrb,
  output logic [31:0]             data_wdata,
  input  logic                    data_addr_ok,
  input  logic                    data_data_ok,
  output logic [CNT_W-1:0]        pending_cnt,
  output logic                    store_drained
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [CNT_W:0] MAX_PENDING = (CNT_W + 1)'(STORE_GROUP);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [2:0]       size_q, size_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             pop;
  logic [CNT_W:0]   retire_cnt;
  logic [CNT_W:0]   pending_sum;

  // Pop decision looks only at the registered count, so a store retired this
  // cycle is never popped in the same cycle it retires.
  assign pop = (state_q == S_IDLE) && (pending_q != '0);

  // Number of retire slots carrying a store this cycle.
  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      retire_cnt = retire_cnt + {{CNT_W{1'b0}}, rob_commit_store[i]};
    end
  end

  // One bit wider than the counter so an overflow is visible to the check
  // below instead of silently wrapping. The ROB bounds the sum, so there is
  // no saturation here.
  assign pending_sum = {1'b0, pending_q} + retire_cnt - {{CNT_W{1'b0}}, pop};
  assign pending_d   = pending_sum[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Accept and completion in the same cycle skip WAIT entirely.
        if (data_addr_ok) begin
          state_d = data_data_ok ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are captured only on a pop, which guarantees they stay
  // stable through REQ and WAIT until the next store is taken.
  always_comb begin
    size_d  = size_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    if (pop) begin
      size_d  = commit_store_size;
      addr_d  = commit_store_addr;
      wstrb_d = commit_store_wstrb;
      wdata_d = commit_store_data;
    end
  end

  // Reset abandons any in-flight write; the dcache is reset alongside.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      size_q    <= '0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
    end
  end

  assign commit_store_valid = pop;
  assign data_req           = (state_q == S_REQ);
  assign data_wr            = data_req;
  assign data_size          = size_q;
  assign data_addr          = addr_q;
  assign data_wstrb         = wstrb_q;
  assign data_wdata         = wdata_q;
  assign pending_cnt        = pending_q;
  assign store_drained      = (state_q == S_IDLE) && (pending_q == '0);

  // The store_buffer can never hold more retired stores than its depth.
  a_pending_no_overflow: assert property (
    @(posedge clk) disable iff (!resetn) pending_sum <= MAX_PENDING
  );

  // Only the three encoded states are ever reachable.
  a_state_legal: assert property (
    @(posedge clk) disable iff (!resetn) state_q != 2'd3
  );

  // A request that has not been accepted keeps its fields unchanged.
  a_req_stable: assert property (
    @(posedge clk) disable iff (!resetn)
      (state_q == S_REQ && !data_addr_ok) |=>
        (state_q == S_REQ) && $stable({size_q, addr_q, wstrb_q, wdata_q})
  );

endmodule

// File: tb/tb_store_drain_unit.sv
module tb_store_drain_unit;

  localparam int STORE_GROUP  = 16;
  localparam int COMMIT_WIDTH = 2;
  localparam int CNT_W        = $clog2(STORE_GROUP + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
    logic [2:0]  size;
  } st_t;

  logic                    clk;
  logic                    resetn;
  logic [COMMIT_WIDTH-1:0] rob_commit_store;
  logic                    commit_store_valid;
  logic [3:0]              commit_store_wstrb;
  logic [2:0]              commit_store_size;
  logic [31:0]             commit_store_addr;
  logic [31:0]             commit_store_data;
  logic                    data_req;
  logic                    data_wr;
  logic [2:0]              data_size;
  logic [31:0]             data_addr;
  logic [3:0]              data_wstrb;
  logic [31:0]             data_wdata;
  logic                    data_addr_ok;
  logic                    data_data_ok;
  logic [CNT_W-1:0]        pending_cnt;
  logic                    store_drained;

  // Store buffer model: entries written by the stimulus, head follows pops.
  st_t        sb_mem [64];
  int         sb_wr;
  int         sb_rd;
  int         ret_idx;
  logic [5:0] head_idx;
  bit         pop_now;

  // Scoreboard of writes the dcache must see, in order.
  st_t exp_q[$];

  int n_tests;
  int n_fail;

  assign head_idx           = sb_rd[5:0];
  assign commit_store_addr  = sb_mem[head_idx].addr;
  assign commit_store_data  = sb_mem[head_idx].data;
  assign commit_store_wstrb = sb_mem[head_idx].wstrb;
  assign commit_store_size  = sb_mem[head_idx].size;

  store_drain_unit #(
    .STORE_GROUP (STORE_GROUP),
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .rob_commit_store  (rob_commit_store),
    .commit_store_valid(commit_store_valid),
    .commit_store_wstrb(commit_store_wstrb),
    .commit_store_size (commit_store_size),
    .commit_store_addr (commit_store_addr),
    .commit_store_data (commit_store_data),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wstrb        (data_wstrb),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .pending_cnt       (pending_cnt),
    .store_drained     (store_drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] z);
    st_t e;
    e.addr  = a;
    e.data  = d;
    e.wstrb = s;
    e.size  = z;
    sb_mem[sb_wr[5:0]] = e;
    sb_wr++;
  endtask

  // One clock cycle. At the falling edge the bench records retirements into
  // the scoreboard, notes a pop, and checks any write accepted at the coming
  // edge. Inputs change 1 time unit after the rising edge.
  task automatic tick();
    st_t e;
    @(negedge clk);
    if (!resetn) begin
      exp_q.delete();
      sb_rd   = sb_wr;
      ret_idx = sb_wr;
      pop_now = 1'b0;
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (rob_commit_store[i]) begin
          exp_q.push_back(sb_mem[ret_idx[5:0]]);
          ret_idx++;
        end
      end
      pop_now = commit_store_valid;
      if (data_req && data_addr_ok) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr",  64'(data_addr),  64'(e.addr));
          chk("wr_data",  64'(data_wdata), 64'(e.data));
          chk("wr_wstrb", 64'(data_wstrb), 64'(e.wstrb));
          chk("wr_size",  64'(data_size),  64'(e.size));
          chk("wr_wr",    64'(data_wr),    64'(1));
        end
      end
    end
    @(posedge clk);
    #1;
    if (pop_now) sb_rd++;
  endtask

  // Dcache responder for one write: wait for the request, hold off the accept
  // for aw cycles, then complete dw cycles after the accept (0 = same cycle).
  task automatic serve(input int aw, input int dw);
    int n;
    n = 0;
    while (!data_req && n < 20) begin
      tick();
      n++;
    end
    if (!data_req) begin
      chk("req_timeout", 64'(data_req), 64'(1));
      return;
    end
    repeat (aw) tick();
    data_addr_ok = 1'b1;
    data_data_ok = (dw == 0);
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (dw > 0) begin
      repeat (dw - 1) tick();
      data_data_ok = 1'b1;
      tick();
      data_data_ok = 1'b0;
    end
  endtask

  task automatic drain_all(input string tag);
    int k;
    k = 0;
    while (!store_drained && k < 40) begin
      serve(k % 3, (k % 4 == 0) ? 0 : (k % 3) + 1);
      k++;
    end
    chk(tag, 64'(store_drained), 64'(1));
    chk({tag, "_sb"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    sb_wr            = 0;
    sb_rd            = 0;
    ret_idx          = 0;
    pop_now          = 1'b0;
    for (int i = 0; i < 64; i++) sb_mem[i] = '0;
    resetn           = 1'b1;
    rob_commit_store = '0;
    data_addr_ok     = 1'b0;
    data_data_ok     = 1'b0;

    // Reset state, observed before any clock edge.
    #2 resetn = 1'b0;
    #1;
    chk("rst_drained", 64'(store_drained),      64'(1));
    chk("rst_req",     64'(data_req),           64'(0));
    chk("rst_wr",      64'(data_wr),            64'(0));
    chk("rst_pop",     64'(commit_store_valid), 64'(0));
    chk("rst_pend",    64'(pending_cnt),        64'(0));
    chk("rst_addr",    64'(data_addr),          64'(0));
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // 1: single store, addr_ok then data_ok two cycles later.
    push_store(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2);
    rob_commit_store = 2'b01;
    tick();
    rob_commit_store = 2'b00;
    chk("t1_pend",     64'(pending_cnt),        64'(1));
    chk("t1_pop",      64'(commit_store_valid), 64'(1));
    chk("t1_noreq",    64'(data_req),           64'(0));
    tick();
    chk("t1_req",      64'(data_req),           64'(1));
    chk("t1_wr",       64'(data_wr),            64'(1));
    chk("t1_addr",     64'(data_addr),          64'(32'h8000_0010));
    chk("t1_data",     64'(data_wdata),         64'(32'hDEAD_BEEF));
    chk("t1_wstrb",    64'(data_wstrb),         64'(4'hF));
    chk("t1_size",     64'(data_size),          64'(3'd2));
    chk("t1_pend0",    64'(pending_cnt),        64'(0));
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("t1_wait_req", 64'(data_req),           64'(0));
    chk("t1_busy",     64'(store_drained),      64'(0));
    tick();
    chk("t1_busy2",    64'(store_drained),      64'(0));
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    chk("t1_drained",  64'(store_drained),      64'(1));

    // 2: two stores retired together, popped one cycle after each completion.
    push_store(32'h0000_1000, 32'h1111_1111, 4'h3, 3'd1);
    push_store(32'h0000_2004, 32'h2222_2222, 4'hC, 3'd1);
    rob_commit_store = 2'b11;
    tick();
    rob_commit_store = 2'b00;
    chk("t2_pend2",    64'(pending_cnt),        64'(2));
    tick();
    chk("t2_addr_a",   64'(data_addr),          64'(32'h0000_1000));
    chk("t2_pend1",    64'(pending_cnt),        64'(1));
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    chk("t2_pop_b",    64'(commit_store_valid), 64'(1));
    tick();
    chk("t2_addr_b",   64'(data_addr),          64'(32'h0000_2004));
    chk("t2_pend0",    64'(pending_cnt),        64'(0));
    serve(0, 1);
    chk("t2_drained",  64'(store_drained),      64'(1));

    // 3 + 4: request held 5 cycles without accept, then accept+complete together.
    push_store(32'h0000_3008, 32'hCAFE_F00D, 4'h1, 3'd0);
    push_store(32'h0000_400C, 32'h0BAD_CAFE, 4'hF, 3'd2);
    rob_commit_store = 2'b11;
    tick();
    rob_commit_store = 2'b00;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t3_req",    64'(data_req),    64'(1));
      chk("t3_addr",   64'(data_addr),   64'(32'h0000_3008));
      chk("t3_data",   64'(data_wdata),  64'(32'hCAFE_F00D));
      chk("t3_wstrb",  64'(data_wstrb),  64'(4'h1));
      chk("t3_size",   64'(data_size),   64'(3'd0));
      chk("t3_pend",   64'(pending_cnt), 64'(1));
      tick();
    end
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    chk("t4_idle_pop", 64'(commit_store_valid), 64'(1));
    chk("t4_noreq",    64'(data_req),           64'(0));
    tick();
    chk("t4_req",      64'(data_req),           64'(1));
    chk("t4_addr",     64'(data_addr),          64'(32'h0000_400C));
    serve(1, 2);
    chk("t4_drained",  64'(store_drained),      64'(1));

    // 5a: retire and pop in the same cycle with pending_cnt=3.
    push_store(32'h0000_5000, 32'h5555_0000, 4'hF, 3'd2);
    rob_commit_store = 2'b01;
    tick();
    rob_commit_store = 2'b00;
    tick();
    for (int j = 1; j <= 3; j++) push_store(32'h0000_5000 + 32'(j * 4), 32'h5555_0000 + 32'(j), 4'hF, 3'd2);
    rob_commit_store = 2'b11;
    tick();
    rob_commit_store = 2'b01;
    tick();
    rob_commit_store = 2'b00;
    chk("t5_pend3",    64'(pending_cnt),        64'(3));
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    chk("t5_pop",      64'(commit_store_valid), 64'(1));
    push_store(32'h0000_5010, 32'h5555_0004, 4'h6, 3'd1);
    rob_commit_store = 2'b01;
    tick();
    rob_commit_store = 2'b00;
    chk("t5_add_pop",  64'(pending_cnt),        64'(3));
    chk("t5_req",      64'(data_req),           64'(1));
    drain_all("t5a_drained");

    // 5b: fill to the full STORE_GROUP while one write is stuck in REQ.
    push_store(32'h0000_6000, 32'h6666_0000, 4'hF, 3'd2);
    rob_commit_store = 2'b01;
    tick();
    rob_commit_store = 2'b00;
    tick();
    for (int j = 0; j < 8; j++) begin
      push_store(32'h0000_7000 + 32'(j * 8),     32'h7777_0000 + 32'(j * 2),     4'hF, 3'd2);
      push_store(32'h0000_7000 + 32'(j * 8 + 4), 32'h7777_0000 + 32'(j * 2 + 1), 4'h5, 3'd1);
      rob_commit_store = 2'b11;
      tick();
    end
    rob_commit_store = 2'b00;
    chk("t5_pend16",   64'(pending_cnt),        64'(16));
    chk("t5_busy",     64'(store_drained),      64'(0));
    drain_all("t5b_drained");

    // 6a: asynchronous reset while a request is outstanding.
    push_store(32'h0000_8000, 32'h8888_0000, 4'hF, 3'd2);
    push_store(32'h0000_8004, 32'h8888_0001, 4'hF, 3'd2);
    push_store(32'h0000_8008, 32'h8888_0002, 4'hF, 3'd2);
    rob_commit_store = 2'b11;
    tick();
    rob_commit_store = 2'b01;
    tick();
    rob_commit_store = 2'b00;
    chk("t6_req_pre",  64'(data_req),           64'(1));
    #2 resetn = 1'b0;
    #1;
    chk("t6_req_rst",  64'(data_req),           64'(0));
    chk("t6_pend_rst", 64'(pending_cnt),        64'(0));
    chk("t6_addr_rst", 64'(data_addr),          64'(0));
    chk("t6_drn_rst",  64'(store_drained),      64'(1));
    tick();
    resetn = 1'b1;
    tick();
    chk("t6_idle",     64'(store_drained),      64'(1));

    // 6b: asynchronous reset in WAIT with one store still pending.
    push_store(32'h0000_9000, 32'h9999_0000, 4'hF, 3'd2);
    push_store(32'h0000_9004, 32'h9999_0001, 4'hF, 3'd2);
    rob_commit_store = 2'b11;
    tick();
    rob_commit_store = 2'b00;
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("t6_wait_req", 64'(data_req),           64'(0));
    chk("t6_wait_pnd", 64'(pending_cnt),        64'(1));
    #2 resetn = 1'b0;
    #1;
    chk("t6w_pend",    64'(pending_cnt),        64'(0));
    chk("t6w_pop",     64'(commit_store_valid), 64'(0));
    chk("t6w_req",     64'(data_req),           64'(0));
    chk("t6w_data",    64'(data_wdata),         64'(0));
    tick();
    resetn = 1'b1;
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    chk("t6w_drained", 64'(store_drained),      64'(1));
    chk("t6w_noreq",   64'(data_req),           64'(0));

    // Recovery after reset.
    push_store(32'h0000_A000, 32'hAAAA_5555, 4'h9, 3'd2);
    rob_commit_store = 2'b01;
    tick();
    rob_commit_store = 2'b00;
    serve(2, 3);
    chk("rec_drained", 64'(store_drained),      64'(1));
    chk("rec_sb",      64'(exp_q.size()),       64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
